// File: rtl/alert_pkg.sv
// Shared state codes, widths and helpers for the alert handler escalation sequencer.
// Sparse 9-bit state codes apply only when ALERT_ESC_SPARSE_FSM_EN is defined.
package alert_pkg;

  localparam int EscCntDw  = 32;
  localparam int NPhases   = 4;
  localparam int PhaseBits = 2;
  localparam int SparseW   = 9;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StTimeout  = 3'd1,
    StPhase0   = 3'd2,
    StPhase1   = 3'd3,
    StPhase2   = 3'd4,
    StPhase3   = 3'd5,
    StTerminal = 3'd6,
    StFsmError = 3'd7
  } esc_state_e;

  // Codewords of a linear code, so every pair differs in at least 3 bits.
  localparam logic [SparseW-1:0] SpIdle     = 9'b000000000;
  localparam logic [SparseW-1:0] SpTimeout  = 9'b001110001;
  localparam logic [SparseW-1:0] SpPhase0   = 9'b010101010;
  localparam logic [SparseW-1:0] SpPhase1   = 9'b011011011;
  localparam logic [SparseW-1:0] SpPhase2   = 9'b100011100;
  localparam logic [SparseW-1:0] SpPhase3   = 9'b101101101;
  localparam logic [SparseW-1:0] SpTerminal = 9'b110110110;
  localparam logic [SparseW-1:0] SpFsmError = 9'b111000111;

  function automatic logic is_phase(esc_state_e st);
    return (st == StPhase0) || (st == StPhase1) || (st == StPhase2) || (st == StPhase3);
  endfunction

  function automatic logic [PhaseBits-1:0] phase_idx(esc_state_e st);
    logic [2:0] code;
    code = st;
    return code[1:0] - 2'd2;
  endfunction

  function automatic logic [SparseW-1:0] sparse_enc(esc_state_e st);
    logic [SparseW-1:0] code;
    case (st)
      StIdle:     code = SpIdle;
      StTimeout:  code = SpTimeout;
      StPhase0:   code = SpPhase0;
      StPhase1:   code = SpPhase1;
      StPhase2:   code = SpPhase2;
      StPhase3:   code = SpPhase3;
      StTerminal: code = SpTerminal;
      default:    code = SpFsmError;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alert_handler_esc_seq_cnt.sv
// Timeout/phase cycle counter with clear, saturating increment and a wide done compare.
// done_o is combinational: high when cnt+1 reaches thresh_i, compared at Dw+1 bits.
module alert_handler_esc_seq_cnt #(
  parameter int Dw = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [Dw-1:0] thresh_i,
  output logic [Dw-1:0] cnt_o,
  output logic          done_o
);

  logic [Dw-1:0] cnt_d, cnt_q;
  logic [Dw:0]   cnt_nxt;

  always_comb begin
    cnt_nxt = {1'b0, cnt_q} + {{Dw{1'b0}}, 1'b1};
    done_o  = cnt_nxt >= {1'b0, thresh_i};
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !cnt_nxt[Dw]) begin
      cnt_d = cnt_nxt[Dw-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/alert_handler_esc_seq.sv
// Per-class escalation sequencer: timeout, four timed phases, terminal and error states.
// Outputs are registered alongside the state; ALERT_ESC_SPARSE_FSM_EN selects a sparse state register.
module alert_handler_esc_seq #(
  parameter int NEscSev  = 4,
  parameter int NPhases  = 4,
  parameter int EscCntDw = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        class_en_i,
  input  logic                        clr_i,
  input  logic                        accu_trig_i,
  input  logic                        accu_fail_i,
  input  logic                        timeout_en_i,
  input  logic [EscCntDw-1:0]         timeout_cyc_i,
  input  logic [NPhases*EscCntDw-1:0] phase_cyc_i,
  input  logic [NEscSev-1:0]          esc_en_i,
  input  logic [NEscSev*2-1:0]        esc_map_i,
  output logic [NEscSev-1:0]          esc_sig_o,
  output logic                        esc_trig_o,
  output logic [EscCntDw-1:0]         esc_cnt_o,
  output logic [2:0]                  esc_state_o,
  output logic                        fsm_fail_o
);
  import alert_pkg::*;

  esc_state_e          cur_state, nxt_state;
  logic                illegal;
  logic                cnt_clr, cnt_inc, cnt_done;
  logic [EscCntDw-1:0] cnt_thresh;
  logic [NEscSev-1:0]  esc_sig_d, esc_sig_q;
  logic                esc_trig_d, esc_trig_q, fsm_fail_d, fsm_fail_q;

`ifdef ALERT_ESC_SPARSE_FSM_EN
  localparam logic [SparseW-1:0] StateRst = SpIdle;
  logic [SparseW-1:0] state_d, state_q;

  always_comb begin
    illegal   = 1'b0;
    cur_state = StIdle;
    case (state_q)
      SpIdle:     cur_state = StIdle;
      SpTimeout:  cur_state = StTimeout;
      SpPhase0:   cur_state = StPhase0;
      SpPhase1:   cur_state = StPhase1;
      SpPhase2:   cur_state = StPhase2;
      SpPhase3:   cur_state = StPhase3;
      SpTerminal: cur_state = StTerminal;
      SpFsmError: cur_state = StFsmError;
      default: begin
        illegal   = 1'b1;
        cur_state = StFsmError;
      end
    endcase
  end

  assign state_d = sparse_enc(nxt_state);
`else
  localparam logic [2:0] StateRst = StIdle;
  logic [2:0] state_d, state_q;

  assign cur_state = esc_state_e'(state_q);
  assign illegal   = 1'b0;
  assign state_d   = nxt_state;
`endif

  always_comb begin
    nxt_state  = cur_state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_thresh = '0;
    case (cur_state)
      StIdle: begin
        cnt_clr = 1'b1;
        if (accu_trig_i && class_en_i) begin
          nxt_state = StPhase0;
        end else if (timeout_en_i && class_en_i && (timeout_cyc_i != '0)) begin
          nxt_state = StTimeout;
        end
      end
      StTimeout: begin
        cnt_thresh = timeout_cyc_i;
        if (!timeout_en_i || !class_en_i) begin
          nxt_state = StIdle;
          cnt_clr   = 1'b1;
        end else if (accu_trig_i || cnt_done) begin
          nxt_state = StPhase0;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StPhase0, StPhase1, StPhase2, StPhase3: begin
        cnt_thresh = phase_cyc_i[phase_idx(cur_state)*EscCntDw +: EscCntDw];
        if (clr_i) begin
          nxt_state = StIdle;
          cnt_clr   = 1'b1;
        end else if (cnt_done) begin
          // Dense codes are consecutive, so Phase3 + 1 lands on Terminal.
          nxt_state = esc_state_e'(cur_state + 3'd1);
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StTerminal: begin
        cnt_clr = 1'b1;
        if (clr_i) nxt_state = StIdle;
      end
      StFsmError: begin
        cnt_clr = 1'b1;
      end
      default: begin
        nxt_state = StIdle;
        cnt_clr   = 1'b1;
      end
    endcase
    if (accu_fail_i || illegal) begin
      nxt_state = StFsmError;
      cnt_clr   = 1'b1;
    end
  end

  always_comb begin
    esc_sig_d = '0;
    for (int j = 0; j < NEscSev; j++) begin
      esc_sig_d[j] = esc_en_i[j] && is_phase(nxt_state) &&
                     (phase_idx(nxt_state) == esc_map_i[2*j +: 2]);
    end
    if (nxt_state == StFsmError) esc_sig_d = '1;
    esc_trig_d = (nxt_state == StPhase0) && (cur_state != StPhase0);
    fsm_fail_d = (nxt_state == StFsmError);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StateRst;
      esc_sig_q  <= '0;
      esc_trig_q <= 1'b0;
      fsm_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      esc_sig_q  <= esc_sig_d;
      esc_trig_q <= esc_trig_d;
      fsm_fail_q <= fsm_fail_d;
    end
  end

  alert_handler_esc_seq_cnt #(
    .Dw(EscCntDw)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .thresh_i (cnt_thresh),
    .cnt_o    (esc_cnt_o),
    .done_o   (cnt_done)
  );

  assign esc_sig_o   = esc_sig_q;
  assign esc_trig_o  = esc_trig_q;
  assign esc_state_o = cur_state;
  assign fsm_fail_o  = fsm_fail_q;

endmodule

// File: tb/tb_alert_handler_esc_seq.sv
// Scoreboard bench for alert_handler_esc_seq: a behavioural model predicts each cycle's outputs,
// a monitor compares them one cycle later; directed scenarios followed by random traffic.
module tb_alert_handler_esc_seq;

  logic         clk = 1'b0;
  logic         rst_i, class_en_i, clr_i, accu_trig_i, accu_fail_i, timeout_en_i;
  logic [31:0]  timeout_cyc_i;
  logic [127:0] phase_cyc_i;
  logic [3:0]   esc_en_i;
  logic [7:0]   esc_map_i;
  logic [3:0]   esc_sig_o;
  logic         esc_trig_o;
  logic [31:0]  esc_cnt_o;
  logic [2:0]   esc_state_o;
  logic         fsm_fail_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  sig;
    logic        trig;
    logic [31:0] cnt;
    logic [2:0]  st;
    logic        fail;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: spec state code and elapsed cycles in that state.
  int     m_st = 0;
  longint m_cnt = 0;
  bit     m_inject = 1'b0;

  always #5 clk = ~clk;

  alert_handler_esc_seq dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .class_en_i    (class_en_i),
    .clr_i         (clr_i),
    .accu_trig_i   (accu_trig_i),
    .accu_fail_i   (accu_fail_i),
    .timeout_en_i  (timeout_en_i),
    .timeout_cyc_i (timeout_cyc_i),
    .phase_cyc_i   (phase_cyc_i),
    .esc_en_i      (esc_en_i),
    .esc_map_i     (esc_map_i),
    .esc_sig_o     (esc_sig_o),
    .esc_trig_o    (esc_trig_o),
    .esc_cnt_o     (esc_cnt_o),
    .esc_state_o   (esc_state_o),
    .fsm_fail_o    (fsm_fail_o)
  );

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Predict the outputs visible after the coming clock edge from the current inputs.
  function automatic exp_t model_step();
    exp_t e;
    int prev = m_st;
    e = '0;
    if (rst_i) begin
      m_st = 0;
      m_cnt = 0;
      return e;
    end
    if (accu_fail_i || m_inject || m_st == 7) begin
      m_st = 7;
      m_cnt = 0;
    end else if (m_st == 0) begin
      if (accu_trig_i && class_en_i) m_st = 2;
      else if (timeout_en_i && class_en_i && timeout_cyc_i != 0) m_st = 1;
      m_cnt = 0;
    end else if (m_st == 1) begin
      if (!timeout_en_i || !class_en_i) begin
        m_st = 0; m_cnt = 0;
      end else if (accu_trig_i || m_cnt + 1 >= longint'(timeout_cyc_i)) begin
        m_st = 2; m_cnt = 0;
      end else m_cnt++;
    end else if (m_st >= 2 && m_st <= 5) begin
      longint dur = longint'(phase_cyc_i[(m_st-2)*32 +: 32]);
      if (dur == 0) dur = 1;
      if (clr_i) begin
        m_st = 0; m_cnt = 0;
      end else if (m_cnt + 1 >= dur) begin
        m_st = (m_st == 5) ? 6 : m_st + 1;
        m_cnt = 0;
      end else m_cnt++;
    end else begin
      m_cnt = 0;
      if (clr_i) m_st = 0;
    end
    for (int j = 0; j < 4; j++) begin
      int mp = int'(esc_map_i[2*j +: 2]);
      e.sig[j] = (m_st == 7) || (esc_en_i[j] && m_st >= 2 && m_st <= 5 && mp == m_st - 2);
    end
    e.trig = (m_st == 2) && (prev != 2);
    e.cnt  = 32'(m_cnt);
    e.st   = 3'(m_st);
    e.fail = (m_st == 7);
    return e;
  endfunction

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_step());
      @(negedge clk);
    end
  endtask

  task automatic set_phases(int p0, int p1, int p2, int p3);
    phase_cyc_i = {32'(p3), 32'(p2), 32'(p1), 32'(p0)};
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("esc_sig", longint'(esc_sig_o), longint'(e.sig));
        chk("esc_trig", longint'(esc_trig_o), longint'(e.trig));
        chk("esc_cnt", longint'(esc_cnt_o), longint'(e.cnt));
        chk("esc_state", longint'(esc_state_o), longint'(e.st));
        chk("fsm_fail", longint'(fsm_fail_o), longint'(e.fail));
      end
    end
  end

  initial begin
    rst_i = 1'b1; class_en_i = 1'b1; clr_i = 1'b0; accu_trig_i = 1'b0;
    accu_fail_i = 1'b0; timeout_en_i = 1'b0; timeout_cyc_i = 32'd10;
    set_phases(4, 4, 4, 4);
    esc_en_i = 4'hF; esc_map_i = 8'b11_10_01_00;
    @(negedge clk);
    tick(2);
    rst_i = 1'b0;
    tick(2);

    // Trigger walk through all phases into Terminal, then clear.
    accu_trig_i = 1'b1; tick(); accu_trig_i = 1'b0;
    tick(20);
    clr_i = 1'b1; tick(); clr_i = 1'b0; tick(2);

    // Timeout expiry, then timeout abandoned after 5 cycles.
    timeout_en_i = 1'b1; tick(14);
    timeout_en_i = 1'b0; clr_i = 1'b1; tick(); clr_i = 1'b0;
    timeout_en_i = 1'b1; tick(6);
    timeout_en_i = 1'b0; tick(3);

    // Zero-length phase 1; trigger ignored while class disabled.
    set_phases(4, 0, 3, 2);
    accu_trig_i = 1'b1; tick(); accu_trig_i = 1'b0;
    tick(12);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    class_en_i = 1'b0; accu_trig_i = 1'b1; tick(3);
    class_en_i = 1'b1; accu_trig_i = 1'b0; tick();

    // Clear in Phase2 at cnt=2; clear ignored in Timeout.
    set_phases(4, 4, 4, 4);
    accu_trig_i = 1'b1; tick(); accu_trig_i = 1'b0;
    tick(10);
    clr_i = 1'b1; tick(); clr_i = 1'b0; tick();
    timeout_en_i = 1'b1; tick(2);
    clr_i = 1'b1; tick(2); clr_i = 1'b0; tick(2);
    timeout_en_i = 1'b0; tick();

    // Tandem failure with simultaneous clear in Phase1, held until reset.
    accu_trig_i = 1'b1; tick(); accu_trig_i = 1'b0;
    tick(5);
    accu_fail_i = 1'b1; clr_i = 1'b1; tick();
    accu_fail_i = 1'b0; clr_i = 1'b0; tick(5);
    rst_i = 1'b1; tick(2); rst_i = 1'b0; tick(2);

`ifdef ALERT_ESC_SPARSE_FSM_EN
    accu_trig_i = 1'b1; tick(); accu_trig_i = 1'b0;
    force dut.state_q = 9'b000000111;
    m_inject = 1'b1; tick(); m_inject = 1'b0;
    release dut.state_q;
    tick(3);
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
`endif

    // Random traffic; configuration varies occasionally, reset recovers from FsmError.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) begin
        set_phases($urandom_range(5), $urandom_range(5), $urandom_range(5), $urandom_range(5));
        timeout_cyc_i = 32'($urandom_range(8));
        esc_en_i = 4'($urandom);
        esc_map_i = 8'($urandom);
      end
      class_en_i   = ($urandom_range(9) != 0);
      accu_trig_i  = ($urandom_range(15) == 0);
      accu_fail_i  = ($urandom_range(399) == 0);
      clr_i        = ($urandom_range(29) == 0);
      if ($urandom_range(9) == 0) timeout_en_i = ~timeout_en_i;
      rst_i        = (m_st == 7) && ($urandom_range(7) == 0);
      tick();
    end
    rst_i = 1'b0; accu_fail_i = 1'b0;
    tick(2);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alert_handler_esc_seq.md
Name: alert_handler_esc_seq

Overview:
- Per-class escalation sequencer, directly downstream of the class accumulator.
- Consumes the accumulator trigger and the tandem-counter failure flag, plus the class interrupt-pending timeout request.
- Walks a programmable 4-phase escalation sequence and drives the per-severity escalation request lines toward the escalation senders.
- Reports FSM state and phase cycle count for CSR readback.

Parameters:
- NEscSev, 4, number of escalation severity outputs.
- NPhases, 4, number of escalation phases (fixed to 4 in this revision).
- EscCntDw, 32, width of timeout/phase cycle counter and thresholds.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- class_en_i  in  1  class enable
- clr_i  in  1  clear request: abort escalation, return to Idle
- accu_trig_i  in  1  escalation trigger from accumulator
- accu_fail_i  in  1  tandem accumulator mismatch
- timeout_en_i  in  1  class interrupt pending (starts timeout)
- timeout_cyc_i  in  EscCntDw  timeout cycles before auto-escalation
- phase_cyc_i  in  NPhases*EscCntDw  per-phase duration in cycles
- esc_en_i  in  NEscSev  per-severity enable
- esc_map_i  in  NEscSev*2  phase index that activates each severity
- esc_sig_o  out  NEscSev  escalation request lines
- esc_trig_o  out  1  one-cycle pulse on entry to Phase0
- esc_cnt_o  out  EscCntDw  current timeout/phase counter
- esc_state_o  out  3  state code: Idle=0, Timeout=1, Phase0..3=2..5, Terminal=6, FsmError=7
- fsm_fail_o  out  1  high in FsmError

Behaviour:
- Reset (sync, rst_i=1 at clock edge):
  - state=Idle, cnt=0.
  - All outputs 0; esc_state_o=0.
- Idle:
  - accu_trig_i & class_en_i -> Phase0, cnt=0, esc_trig_o=1 next cycle.
  - Else timeout_en_i & class_en_i & timeout_cyc_i!=0 -> Timeout, cnt=0.
  - Trigger has priority over timeout when both are asserted.
- Timeout:
  - !timeout_en_i or !class_en_i -> Idle, cnt=0.
  - Else accu_trig_i or (cnt+1 >= timeout_cyc_i) -> Phase0, cnt=0, esc_trig_o pulse.
  - Else cnt++.
- PhaseK (K=0..3):
  - Phase duration is max(phase_cyc_i[K],1) cycles.
  - When cnt+1 >= phase_cyc_i[K], compared at EscCntDw+1 bits: move to PhaseK+1 (Phase3 -> Terminal), cnt=0.
  - Else cnt++.
  - class_en_i and accu_trig_i are ignored once escalating.
- Terminal: hold, cnt=0, until clr_i.
- clr_i:
  - In PhaseK or Terminal -> Idle, cnt=0.
  - No effect in Idle or Timeout.
- accu_fail_i: from any state -> FsmError. This has the highest priority, above clr_i.
- FsmError:
  - Absorbing; exits only on rst_i.
  - All esc_sig_o=1 regardless of esc_en_i; fsm_fail_o=1; cnt=0.
- esc_sig_o[j] (registered, same cycle as state):
  - = esc_en_i[j] & state==Phase(esc_map_i[j]).
  - In Terminal: 0 for all j.
- esc_trig_o: registered, 1 exactly in the first cycle the state is Phase0.
- Counter never wraps; all comparisons use EscCntDw+1 bits.
- Configuration inputs may change at any time; they are sampled every cycle with no shadowing.

Optional Feature:
- Macro: ALERT_ESC_SPARSE_FSM_EN.
- Defined:
  - State register uses a 9-bit sparse encoding, minimum Hamming distance 3, package constants.
  - Any unlisted encoding -> FsmError next cycle.
  - esc_state_o is still the dense 3-bit code.
- Undefined:
  - Dense 3-bit binary encoding.
  - Illegal codes are unreachable; the default branch -> Idle.

Decomposition:
- alert_pkg gains:
  - EscCntDw.
  - NPhases.
  - esc_state_e (dense codes).
  - Sparse state constants.
  - PhaseBits=2.
- One sub-module: alert_handler_esc_seq_cnt.
  - Counter with clear, increment, and the wide compare.
  - Produces cnt and done.

Test Plan:
- Trigger: phase_cyc_i={4,4,4,4}, esc_map_i[j]=j, esc_en_i=4'hF, pulse accu_trig_i -> esc_trig_o 1 cycle; esc_sig_o=0001, 0010, 0100, 1000 for 4 cycles each; then Terminal with esc_sig_o=0.
- Timeout: timeout_cyc_i=10, timeout_en_i held -> Phase0 entered exactly 10 cycles after Timeout entry. Deasserting timeout_en_i at cycle 5 -> Idle, no escalation.
- Zero-length phase: phase_cyc_i[1]=0 -> Phase1 lasts 1 cycle. class_en_i=0 with accu_trig_i=1 in Idle -> stays Idle.
- Clear: clr_i in Phase2 at cnt=2 -> Idle next cycle, esc_sig_o=0. clr_i in Timeout -> ignored.
- Failure: accu_fail_i in Phase1 together with clr_i -> FsmError, esc_sig_o=4'hF, fsm_fail_o=1, held until rst_i. Reset -> Idle with all outputs 0.
- With ALERT_ESC_SPARSE_FSM_EN: force an illegal state value in Phase0 -> FsmError next cycle, fsm_fail_o=1.
